// File: rtl/amp_seq_pkg.sv
// Shared types and constants for the amplifier power/mute sequencer.
// Holds the state encoding and the per-state pin decode.
package amp_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF      = 3'd0,
    ST_PWR_UP   = 3'd1,
    ST_WAKE     = 3'd2,
    ST_WAIT_CLK = 3'd3,
    ST_RUN      = 3'd4,
    ST_MUTE_DN  = 3'd5,
    ST_SLEEP    = 3'd6,
    ST_FAULT    = 3'd7
  } seq_state_e;

  typedef struct packed {
    logic pwr_en;
    logic standby_n;
    logic mute_n;
  } amp_pins_t;

  localparam amp_pins_t PINS_OFF     = 3'b000;
  localparam amp_pins_t PINS_SUPPLY  = 3'b100;
  localparam amp_pins_t PINS_AWAKE   = 3'b110;
  localparam amp_pins_t PINS_PLAYING = 3'b111;

  function automatic amp_pins_t decode_pins(input seq_state_e s);
    case (s)
      ST_PWR_UP:   return PINS_SUPPLY;
      ST_WAKE:     return PINS_AWAKE;
      ST_WAIT_CLK: return PINS_AWAKE;
      ST_RUN:      return PINS_PLAYING;
      ST_MUTE_DN:  return PINS_AWAKE;
      ST_SLEEP:    return PINS_SUPPLY;
      default:     return PINS_OFF;
    endcase
  endfunction

  function automatic logic is_timed(input seq_state_e s);
    return (s == ST_PWR_UP) || (s == ST_WAKE) || (s == ST_MUTE_DN) ||
           (s == ST_SLEEP)  || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Shared reloadable dwell down-counter for the amplifier sequencer.
// Loads a value, counts down to zero and holds there.
module seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             timeout_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A load is only issued on the edge that leaves the current dwell, so the
  // zero flag always belongs to the state being timed, never to a fresh load.
  assign timeout_o = (cnt_q == '0);

endmodule

// File: rtl/amp_seq_ctrl.sv
// Power/mute sequencer for the external class-D amplifier.
// FSM, per-state dwell selection for the shared timer, and fault bookkeeping.
module amp_seq_ctrl
  import amp_seq_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int T_PWR   = 1000,
  parameter int T_WAKE  = 500,
  parameter int T_MUTE  = 200,
  parameter int T_SLEEP = 200,
  parameter int T_RETRY = 10000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               fault_i,
  input  logic               i2s_valid_i,
  output logic               amp_pwr_en_o,
  output logic               amp_standby_n_o,
  output logic               amp_mute_n_o,
  output logic               ready_o,
  output logic               fault_latched_o,
  output logic [7:0]         fault_cnt_o,
  output logic [STATE_W-1:0] seq_state_o
);

  seq_state_e       state_q, state_d;
  logic             fault_latched_q, fault_latched_d;
  logic [7:0]       fault_cnt_q, fault_cnt_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_timeout;
  logic             retry_reload;
  logic             fault_entry;
  amp_pins_t        pins;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (en_i && !fault_i) state_d = ST_PWR_UP;
      end
      ST_PWR_UP: begin
        if (!en_i)            state_d = ST_OFF;
        else if (tmr_timeout) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (!en_i)            state_d = ST_SLEEP;
        else if (tmr_timeout) state_d = ST_WAIT_CLK;
      end
      ST_WAIT_CLK: begin
        if (!en_i)            state_d = ST_SLEEP;
        else if (i2s_valid_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en_i || !i2s_valid_i) state_d = ST_MUTE_DN;
      end
      ST_MUTE_DN: begin
        // The mute ramp always completes; en is only looked at on its last cycle.
        if (tmr_timeout) state_d = en_i ? ST_WAIT_CLK : ST_SLEEP;
      end
      ST_SLEEP: begin
        if (tmr_timeout) state_d = ST_OFF;
      end
      ST_FAULT: begin
        if (tmr_timeout && !fault_i) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    if (fault_i && (state_q != ST_OFF) && (state_q != ST_FAULT)) begin
      state_d = ST_FAULT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // A retry that finds the fault still present re-arms the FAULT dwell in place.
  assign retry_reload = (state_q == ST_FAULT) && tmr_timeout && fault_i;
  assign tmr_load     = ((state_d != state_q) && is_timed(state_d)) || retry_reload;

  always_comb begin
    tmr_load_val = '0;
    case (state_d)
      ST_PWR_UP:  tmr_load_val = CNT_W'(T_PWR - 1);
      ST_WAKE:    tmr_load_val = CNT_W'(T_WAKE - 1);
      ST_MUTE_DN: tmr_load_val = CNT_W'(T_MUTE - 1);
      ST_SLEEP:   tmr_load_val = CNT_W'(T_SLEEP - 1);
      ST_FAULT:   tmr_load_val = CNT_W'(T_RETRY - 1);
      default:    tmr_load_val = '0;
    endcase
  end

  seq_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .timeout_o  (tmr_timeout)
  );

  assign fault_entry = (state_d == ST_FAULT) && (state_q != ST_FAULT);

  always_comb begin
    fault_latched_d = fault_latched_q;
    if (fault_entry) begin
      fault_latched_d = 1'b1;
    end else if ((state_q == ST_OFF) && !en_i) begin
      fault_latched_d = 1'b0;
    end

    fault_cnt_d = fault_cnt_q;
    if (fault_entry && (fault_cnt_q != 8'hFF)) begin
      fault_cnt_d = fault_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fault_latched_q <= 1'b0;
      fault_cnt_q     <= 8'd0;
    end else begin
      fault_latched_q <= fault_latched_d;
      fault_cnt_q     <= fault_cnt_d;
    end
  end

  assign pins            = decode_pins(state_q);
  assign amp_pwr_en_o    = pins.pwr_en;
  assign amp_standby_n_o = pins.standby_n;
  assign amp_mute_n_o    = pins.mute_n;
  assign ready_o         = (state_q == ST_RUN);
  assign fault_latched_o = fault_latched_q;
  assign fault_cnt_o     = fault_cnt_q;
  assign seq_state_o     = state_q;

endmodule

// File: tb/tb_amp_seq_ctrl.sv
// Directed self-checking bench for amp_seq_ctrl with short dwell times.
module tb_amp_seq_ctrl;

  localparam int S_OFF = 0, S_PWR = 1, S_WAKE = 2, S_WCLK = 3,
                 S_RUN = 4, S_MUTE = 5, S_SLEEP = 6, S_FAULT = 7;

  logic       clk = 1'b0;
  logic       reset, en, fault, i2s_valid;
  logic       amp_pwr_en, amp_standby_n, amp_mute_n, ready, fault_latched;
  logic [7:0] fault_cnt;
  logic [2:0] seq_state;

  int n_tests = 0;
  int n_fail  = 0;

  amp_seq_ctrl #(
    .CNT_W(16), .T_PWR(4), .T_WAKE(3), .T_MUTE(2), .T_SLEEP(2), .T_RETRY(8)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .en_i            (en),
    .fault_i         (fault),
    .i2s_valid_i     (i2s_valid),
    .amp_pwr_en_o    (amp_pwr_en),
    .amp_standby_n_o (amp_standby_n),
    .amp_mute_n_o    (amp_mute_n),
    .ready_o         (ready),
    .fault_latched_o (fault_latched),
    .fault_cnt_o     (fault_cnt),
    .seq_state_o     (seq_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pwr/stby_n/mute_n expected per state
  function automatic logic [2:0] exp_pins(input int s);
    case (s)
      S_PWR:   return 3'b100;
      S_WAKE:  return 3'b110;
      S_WCLK:  return 3'b110;
      S_RUN:   return 3'b111;
      S_MUTE:  return 3'b110;
      S_SLEEP: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic expect_seq(input string tag, input int s, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, ".state"}, 32'(seq_state), 32'(s));
      chk({tag, ".pins"}, 32'({amp_pwr_en, amp_standby_n, amp_mute_n}), 32'(exp_pins(s)));
      chk({tag, ".ready"}, 32'(ready), (s == S_RUN) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; fault = 1'b0; i2s_valid = 1'b0;
    tick(); tick();
    chk("rst.state", 32'(seq_state), S_OFF);
    chk("rst.pins", 32'({amp_pwr_en, amp_standby_n, amp_mute_n}), 0);
    chk("rst.ready", 32'(ready), 0);
    chk("rst.flat", 32'(fault_latched), 0);
    chk("rst.fcnt", 32'(fault_cnt), 0);

    // power-up
    reset = 1'b0; en = 1'b1; i2s_valid = 1'b1;
    expect_seq("pu.pwr", S_PWR, 4);
    expect_seq("pu.wake", S_WAKE, 3);
    expect_seq("pu.wclk", S_WCLK, 1);
    expect_seq("pu.run", S_RUN, 1);

    // clock loss for one cycle
    i2s_valid = 1'b0;
    expect_seq("cl.mute0", S_MUTE, 1);
    i2s_valid = 1'b1;
    expect_seq("cl.mute1", S_MUTE, 1);
    expect_seq("cl.wclk", S_WCLK, 1);
    expect_seq("cl.run", S_RUN, 1);

    // graceful shutdown
    en = 1'b0;
    expect_seq("sd.mute", S_MUTE, 2);
    expect_seq("sd.sleep", S_SLEEP, 2);
    expect_seq("sd.off", S_OFF, 2);
    chk("sd.flat", 32'(fault_latched), 0);

    // fault in WAKE, held across one retry, then cleared
    en = 1'b1;
    expect_seq("fr.pwr", S_PWR, 4);
    expect_seq("fr.wake", S_WAKE, 1);
    fault = 1'b1;
    expect_seq("fr.f0", S_FAULT, 1);
    chk("fr.flat", 32'(fault_latched), 1);
    chk("fr.fcnt", 32'(fault_cnt), 1);
    expect_seq("fr.f1", S_FAULT, 7);
    expect_seq("fr.reload", S_FAULT, 1);
    fault = 1'b0;
    expect_seq("fr.f2", S_FAULT, 7);
    expect_seq("fr.off", S_OFF, 1);
    chk("fr.flat_hold", 32'(fault_latched), 1);
    chk("fr.fcnt_reload", 32'(fault_cnt), 1);
    en = 1'b0;
    expect_seq("fr.off2", S_OFF, 1);
    chk("fr.flat_clr", 32'(fault_latched), 0);

    // fault beats en=0 in RUN
    en = 1'b1;
    expect_seq("pr.pwr", S_PWR, 4);
    expect_seq("pr.wake", S_WAKE, 3);
    expect_seq("pr.wclk", S_WCLK, 1);
    expect_seq("pr.run", S_RUN, 1);
    fault = 1'b1; en = 1'b0;
    expect_seq("pr.fault", S_FAULT, 1);
    chk("pr.fcnt", 32'(fault_cnt), 2);
    fault = 1'b0;
    expect_seq("pr.fhold", S_FAULT, 7);
    expect_seq("pr.off", S_OFF, 2);

    // en=0 on the PWR_UP timeout cycle
    en = 1'b1;
    expect_seq("pt.pwr", S_PWR, 4);
    en = 1'b0;
    expect_seq("pt.off", S_OFF, 1);

    // reset mid-RUN
    en = 1'b1;
    expect_seq("rr.pwr", S_PWR, 4);
    expect_seq("rr.wake", S_WAKE, 3);
    expect_seq("rr.wclk", S_WCLK, 1);
    expect_seq("rr.run", S_RUN, 1);
    reset = 1'b1;
    expect_seq("rr.off", S_OFF, 1);
    chk("rr.fcnt", 32'(fault_cnt), 0);
    chk("rr.flat", 32'(fault_latched), 0);
    reset = 1'b0; en = 1'b0;
    tick();

    // fault while OFF keeps the block off
    en = 1'b1; fault = 1'b1;
    expect_seq("of.off", S_OFF, 1);
    chk("of.fcnt", 32'(fault_cnt), 0);
    fault = 1'b0;

    // repeated fault entries saturate the counter
    for (int i = 0; i < 300; i++) begin
      tick();
      fault = 1'b1;
      tick();
      fault = 1'b0;
      repeat (8) tick();
      if (i == 0)   chk("sat.first", 32'(fault_cnt), 1);
      if (i == 253) chk("sat.254", 32'(fault_cnt), 254);
    end
    chk("sat.fcnt", 32'(fault_cnt), 255);
    chk("sat.state", 32'(seq_state), S_OFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
